// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//   Two-requester arbiter in front of a single BRAM port. Grants are
//   combinational and the access goes to the BRAM in the same cycle. Read
//   data comes back one cycle later on the shared rdata_o, which is
//   qualified by rvalid0_o or rvalid1_o.
//   Arbitration order:
//     - a single requester is always granted;
//     - on contention, a locked owner wins;
//     - otherwise a 1-bit round-robin pointer picks the winner.
//   A requester can hold a lock for at most MaxLock consecutive grants.
// Ports
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   reqN_i/lockN_i/weN_i          request, keep-ownership, write enable
//   wmaskN_i/addrN_i/wdataN_i     per-requester access fields
//   gntN_o                        same-cycle grant
//   rvalidN_o, rdata_o            read return (rdata shared)
//   bram_*_o, bram_rdata_i        device-side BRAM port
module bram_port_arbiter #(
  parameter int AddrWidth = 8,
  parameter int DataWidth = 64,
  parameter int MaxLock   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req0_i,
  input  logic                   req1_i,
  input  logic                   lock0_i,
  input  logic                   lock1_i,
  input  logic                   we0_i,
  input  logic                   we1_i,
  input  logic [DataWidth/8-1:0] wmask0_i,
  input  logic [DataWidth/8-1:0] wmask1_i,
  input  logic [AddrWidth-1:0]   addr0_i,
  input  logic [AddrWidth-1:0]   addr1_i,
  input  logic [DataWidth-1:0]   wdata0_i,
  input  logic [DataWidth-1:0]   wdata1_i,
  output logic                   gnt0_o,
  output logic                   gnt1_o,
  output logic                   rvalid0_o,
  output logic                   rvalid1_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   bram_en_o,
  output logic                   bram_we_o,
  output logic [DataWidth/8-1:0] bram_wmask_o,
  output logic [AddrWidth-1:0]   bram_addr_o,
  output logic [DataWidth-1:0]   bram_wdata_o,
  input  logic [DataWidth-1:0]   bram_rdata_i
);

  localparam logic [3:0] MaxCnt  = 4'(MaxLock);
  // With MaxLock=1 the grant that would enter the lock is already the
  // last locked grant, so the lock is never entered.
  localparam bit         CanLock = (MaxLock > 1);

  typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} state_t;

  state_t     state;
  logic       ptr;   // 0: requester 0 wins the next contended cycle
  logic [3:0] cnt;

  // Combinational arbitration. Everything is forced idle while reset is
  // asserted.
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (rst_ni) begin
      if (req0_i && req1_i) begin
        if (state == LOCKED0)      gnt0_o = 1'b1;
        else if (state == LOCKED1) gnt1_o = 1'b1;
        else if (ptr)              gnt1_o = 1'b1;
        else                       gnt0_o = 1'b1;
      end else begin
        gnt0_o = req0_i;
        gnt1_o = req1_i;
      end
    end
  end

  assign bram_en_o    = gnt0_o | gnt1_o;
  assign bram_we_o    = (gnt0_o & we0_i) | (gnt1_o & we1_i);
  assign bram_wmask_o = !bram_we_o ? '0 : (gnt1_o ? wmask1_i : wmask0_i);
  assign bram_addr_o  = gnt0_o ? addr0_i  : (gnt1_o ? addr1_i  : '0);
  assign bram_wdata_o = gnt0_o ? wdata0_i : (gnt1_o ? wdata1_i : '0);
  assign rdata_o      = (rvalid0_o | rvalid1_o) ? bram_rdata_i : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= UNLOCKED;
      ptr       <= 1'b0;
      cnt       <= 4'd0;
      rvalid0_o <= 1'b0;
      rvalid1_o <= 1'b0;
    end else begin
      rvalid0_o <= gnt0_o & ~we0_i;
      rvalid1_o <= gnt1_o & ~we1_i;
      case (state)
        UNLOCKED: begin
          if (gnt0_o || gnt1_o) begin
            ptr <= gnt0_o;  // point at the requester that lost this cycle
            if (CanLock && gnt0_o && lock0_i) begin
              state <= LOCKED0;
              cnt   <= 4'd1;
            end else if (CanLock && gnt1_o && lock1_i) begin
              state <= LOCKED1;
              cnt   <= 4'd1;
            end
          end
        end
        LOCKED0: begin
          if (!req0_i) begin
            state <= UNLOCKED;
            cnt   <= 4'd0;
            if (gnt1_o) ptr <= 1'b0;
          end else if (gnt0_o) begin
            if (!lock0_i || (cnt + 4'd1 == MaxCnt)) begin
              // Release hands the next contended cycle to the other side.
              state <= UNLOCKED;
              cnt   <= 4'd0;
              ptr   <= 1'b1;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        LOCKED1: begin
          if (!req1_i) begin
            state <= UNLOCKED;
            cnt   <= 4'd0;
            if (gnt0_o) ptr <= 1'b1;
          end else if (gnt1_o) begin
            if (!lock1_i || (cnt + 4'd1 == MaxCnt)) begin
              state <= UNLOCKED;
              cnt   <= 4'd0;
              ptr   <= 1'b0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        default: begin
          state <= UNLOCKED;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter.
//   - The stimulus process drives one cycle per step.
//   - Each step pushes the hand-chosen winner's expected BRAM access, plus
//     an expected read return for reads.
//   - A negedge monitor pops an expectation whenever the DUT shows an
//     access or an rvalid.
//   - During reset, the monitor checks that all outputs are idle.
//   - The BRAM model returns CAFE..<addr> one cycle after a read.
module tb_bram_port_arbiter;

  localparam logic [63:0] RdTag = 64'hCAFE_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req0, req1, lock0, lock1, we0, we1;
  logic [7:0]  wmask0, wmask1, addr0, addr1;
  logic [63:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [63:0] rdata;
  logic        bram_en, bram_we;
  logic [7:0]  bram_wmask, bram_addr;
  logic [63:0] bram_wdata;
  logic [63:0] bram_rdata = 64'h5555_5555_5555_5555;

  logic [83:0] acc_q[$];  // {en,gnt0,gnt1,we,wmask,addr,wdata}
  logic [65:0] rd_q[$];   // {rvalid0,rvalid1,rdata}
  int          checks = 0;
  int          errors = 0;
  logic        done = 1'b0;

  always #5 clk = ~clk;

  bram_port_arbiter #(.AddrWidth(8), .DataWidth(64), .MaxLock(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req0_i(req0), .req1_i(req1), .lock0_i(lock0), .lock1_i(lock1),
    .we0_i(we0), .we1_i(we1), .wmask0_i(wmask0), .wmask1_i(wmask1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .rdata_o(rdata), .bram_en_o(bram_en), .bram_we_o(bram_we),
    .bram_wmask_o(bram_wmask), .bram_addr_o(bram_addr),
    .bram_wdata_o(bram_wdata), .bram_rdata_i(bram_rdata)
  );

  // BRAM device model: registered read data; stale data otherwise.
  always @(posedge clk)
    if (bram_en && !bram_we) bram_rdata <= RdTag | {56'h0, bram_addr};

  task automatic set_in(input logic r0, l0, w0, input logic [7:0] m0, a0,
                        input logic [63:0] d0,
                        input logic r1, l1, w1, input logic [7:0] m1, a1,
                        input logic [63:0] d1);
    req0 = r0; lock0 = l0; we0 = w0; wmask0 = m0; addr0 = a0; wdata0 = d0;
    req1 = r1; lock1 = l1; we1 = w1; wmask1 = m1; addr1 = a1; wdata1 = d1;
  endtask

  // exp_g: 0 idle, 1 requester 0 wins, 2 requester 1 wins
  task automatic step(input logic r0, l0, w0, input logic [7:0] m0, a0,
                      input logic [63:0] d0,
                      input logic r1, l1, w1, input logic [7:0] m1, a1,
                      input logic [63:0] d1, input int exp_g);
    @(posedge clk); #1;
    set_in(r0, l0, w0, m0, a0, d0, r1, l1, w1, m1, a1, d1);
    if (exp_g == 1) begin
      acc_q.push_back({1'b1, 1'b1, 1'b0, w0, (w0 ? m0 : 8'h00), a0, d0});
      if (!w0) rd_q.push_back({2'b10, RdTag | {56'h0, a0}});
    end else if (exp_g == 2) begin
      acc_q.push_back({1'b1, 1'b0, 1'b1, w1, (w1 ? m1 : 8'h00), a1, d1});
      if (!w1) rd_q.push_back({2'b01, RdTag | {56'h0, a1}});
    end
  endtask

  task automatic rd2(input logic r0, l0, input logic [7:0] a0,
                     input logic r1, l1, input logic [7:0] a1, input int exp_g);
    step(r0, l0, 1'b0, 8'h00, a0, 64'h0, r1, l1, 1'b0, 8'h00, a1, 64'h0, exp_g);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [83:0] ea, ga;
    logic [65:0] er, gr;
    if (done) begin
      checks++;
      if (acc_q.size() != 0) begin
        errors++;
        $display("FAIL acc_drain: got %0d pending, exp 0", acc_q.size());
      end
      checks++;
      if (rd_q.size() != 0) begin
        errors++;
        $display("FAIL rd_drain: got %0d pending, exp 0", rd_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end else if (!rst_ni) begin
      checks++;
      if ({gnt0, gnt1, bram_en, bram_we, bram_wmask, bram_addr, bram_wdata,
           rvalid0, rvalid1, rdata} !== '0) begin
        errors++;
        $display("FAIL reset_idle: got gnt=%b%b en=%b we=%b rv=%b%b rdata=%h, exp all 0",
                 gnt0, gnt1, bram_en, bram_we, rvalid0, rvalid1, rdata);
      end
    end else begin
      if (gnt0 || gnt1 || bram_en) begin
        checks++;
        ga = {bram_en, gnt0, gnt1, bram_we, bram_wmask, bram_addr, bram_wdata};
        if (acc_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_access: got %h, exp none", ga);
        end else begin
          ea = acc_q.pop_front();
          if (ga !== ea) begin
            errors++;
            $display("FAIL access: got %h, exp %h", ga, ea);
          end
        end
      end
      if (rvalid0 || rvalid1) begin
        checks++;
        gr = {rvalid0, rvalid1, rdata};
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rvalid: got %h, exp none", gr);
        end else begin
          er = rd_q.pop_front();
          if (gr !== er) begin
            errors++;
            $display("FAIL read_return: got %h, exp %h", gr, er);
          end
        end
      end else begin
        checks++;
        if (rdata !== 64'h0) begin
          errors++;
          $display("FAIL rdata_idle: got %h, exp 0", rdata);
        end
      end
    end
  end

  initial begin
    // Reset with both requesting: all outputs must stay idle.
    set_in(1, 0, 0, 8'h00, 8'h00, 64'h0, 1, 0, 0, 8'h00, 8'h01, 64'h0);
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    set_in(0, 0, 0, 8'h00, 8'h00, 64'h0, 0, 0, 0, 8'h00, 8'h00, 64'h0);

    // Contended reads alternate 0,1,0,1.
    rd2(1, 0, 8'h00, 1, 0, 8'h01, 1);
    rd2(1, 0, 8'h00, 1, 0, 8'h01, 2);
    rd2(1, 0, 8'h00, 1, 0, 8'h01, 1);
    rd2(1, 0, 8'h00, 1, 0, 8'h01, 2);
    rd2(0, 0, 8'h00, 0, 0, 8'h00, 0);
    // Lone write by 1: no rvalid.
    step(0, 0, 0, 8'h00, 8'h00, 64'h0, 1, 0, 1, 8'hFF, 8'h00, 64'h1234, 2);
    // Read with wmask set: mask must not reach the BRAM.
    step(1, 0, 0, 8'hFF, 8'h42, 64'h0, 0, 0, 0, 8'h00, 8'h00, 64'h0, 1);
    step(0, 0, 0, 8'h00, 8'h00, 64'h0, 1, 0, 1, 8'h0F, 8'h05, 64'hABCD, 2);

    // Lock 0 with MaxLock=4: 0,0,0,0 then 1, then 0 again.
    rd2(1, 1, 8'h10, 1, 0, 8'h20, 1);
    rd2(1, 1, 8'h11, 1, 0, 8'h20, 1);
    rd2(1, 1, 8'h12, 1, 0, 8'h20, 1);
    rd2(1, 1, 8'h13, 1, 0, 8'h20, 1);
    rd2(1, 1, 8'h14, 1, 0, 8'h21, 2);
    rd2(1, 1, 8'h15, 1, 0, 8'h22, 1);
    // Locked owner drops req: lock released, normal alternation resumes.
    rd2(0, 1, 8'h16, 1, 0, 8'h23, 2);
    rd2(1, 0, 8'h17, 1, 0, 8'h24, 1);
    rd2(1, 0, 8'h18, 1, 0, 8'h25, 2);
    // Voluntary release of lock 0.
    rd2(1, 1, 8'h30, 1, 0, 8'h40, 1);
    rd2(1, 1, 8'h31, 1, 0, 8'h40, 1);
    rd2(1, 0, 8'h32, 1, 0, 8'h40, 1);
    rd2(1, 0, 8'h33, 1, 0, 8'h41, 2);
    // Lock 1 overrides a pointer favouring 0.
    rd2(0, 0, 8'h00, 1, 1, 8'h50, 2);
    rd2(1, 0, 8'h60, 1, 1, 8'h51, 2);
    rd2(1, 0, 8'h61, 1, 0, 8'h52, 2);
    rd2(1, 0, 8'h62, 1, 0, 8'h53, 1);

    // Granted read by 0, then reset at the next edge: no rvalid.
    rd2(1, 0, 8'h77, 0, 0, 8'h00, 1);
    @(negedge clk); #2;
    rst_ni = 1'b0;
    void'(rd_q.pop_back());
    @(posedge clk); #1;
    set_in(1, 1, 0, 8'h00, 8'h78, 64'h0, 1, 0, 0, 8'h00, 8'h79, 64'h0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    set_in(0, 0, 0, 8'h00, 8'h00, 64'h0, 0, 0, 0, 8'h00, 8'h00, 64'h0);
    // Pointer back to 0 after reset.
    rd2(1, 0, 8'h80, 1, 0, 8'h81, 1);
    rd2(1, 0, 8'h80, 1, 0, 8'h81, 2);

    @(posedge clk); #1;
    set_in(0, 0, 0, 8'h00, 8'h00, 64'h0, 0, 0, 0, 8'h00, 8'h00, 64'h0);
    repeat (3) @(negedge clk);
    #1 done = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL monitor_finish: got no summary, exp summary");
    $fatal(1, "monitor did not finish");
  end

endmodule
